wide_cmp_seq: RTL and testbench
===============================

Name: wide_cmp_seq

Overview:
- Sequencer that compares two wide operands (K slices of N bits) by time-multiplexing one N-bit magnitude comparator (cmp_n), one slice per cycle, MSB slice first.
- Terminates early on the first unequal slice.
- Sits between an operand producer and a result consumer, with valid/ready on both sides.
- Lets wide compares reuse a single narrow comparator instead of a W-bit one.

Parameters:
- N, 8, slice width (width of the cmp_n instance)
- K, 4, number of slices per operand; K >= 1
- W, N*K, operand width (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand pair A/B valid
- in_ready  out  1  block can accept a new pair
- A  in  W  operand A, unsigned
- B  in  W  operand B, unsigned
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- Go  out  1  A > B
- Eo  out  1  A == B
- Lo  out  1  A < B
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- States: IDLE, CMP, DONE.
- Reset, sampled when rst_n=0 at a clk edge, from any state including mid-compare:
  - state=IDLE, idx=K-1, Go=Eo=Lo=0, out_valid=0.
  - Latched operands are don't-care.
  - in_ready=0 while rst_n=0.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch A/B into a_q/b_q, idx=K-1, go to CMP.
- CMP:
  - in_ready=0.
  - Comparator inputs are a_q[idx*N +: N] and b_q[idx*N +: N].
  - Comparator Go or Lo: register Go/Lo, clear Eo, go to DONE.
  - Comparator Eo with idx==0: register Eo=1, Go=Lo=0, go to DONE.
  - Otherwise: idx <= idx-1.
- DONE:
  - out_valid=1; Go/Eo/Lo held stable, exactly one of them is 1.
  - On out_ready: out_valid<=0, go to IDLE.
  - in_ready stays 0 in DONE, including the out_ready cycle. There is no same-cycle accept; the next accept is possible one cycle later.
- Latency, handshake to out_valid: (number of CMP cycles) + 1, where CMP cycles is 1..K.
  - Best case: decided on the top slice, out_valid 2 cycles after accept.
  - Worst case: equal operands, K+1 cycles.
- Throughput: one result per (CMP cycles + 2) cycles, minimum.
- Go/Eo/Lo are registered and valid only while out_valid=1. They keep the last result after returning to IDLE, until the next decision or reset.
- A/B changes after acceptance have no effect.
- K=1: a single CMP cycle always decides.
- idx width is clog2(K), minimum 1 bit. idx never wraps, because CMP exits at idx==0.

Optional Feature:
- Macro WIDE_CMP_SIGNED_EN.
- Defined:
  - A/B are treated as two's complement.
  - When idx==K-1, bit N-1 of both comparator inputs is inverted before comparison.
  - Lower slices are compared unsigned.
- Undefined: pure unsigned compare, no inversion logic synthesized.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE=2'd0, ST_CMP=2'd1, ST_DONE=2'd2
  - a clog2 function for the idx width
- Sub-module: one cmp_n instance (parameter N; ports A, B, Go, Eo, Lo), purely combinational.
- All sequencing lives in wide_cmp_seq.

Test Plan (N=8, K=4):
- A=32'h12345678, B=32'h12345679, out_ready=1 -> 4 CMP cycles, out_valid 5 cycles after accept, Lo=1, Go=Eo=0.
- A=32'hFF000000, B=32'h01000000 -> early exit after 1 CMP cycle, out_valid 2 cycles after accept, Go=1; busy high exactly 3 cycles, out_ready cycle included.
- A=B=32'hDEADBEEF -> Eo=1 after 4 CMP cycles; in_ready=0 throughout CMP and DONE.
- Backpressure: A=32'h5, B=32'h3, out_ready low for 5 cycles in DONE -> out_valid and Go=1 stable all 5 cycles. Raise out_ready -> IDLE next cycle; in_ready=1 one cycle after the out_ready handshake, not the same cycle.
- Reset mid-op: assert rst_n=0 on the 2nd CMP cycle of an equal pair -> next cycle state=IDLE, out_valid=0, Go=Eo=Lo=0. The first post-reset accept of A=32'h2, B=32'h1 yields Go=1.
- A=32'h80000000, B=32'h00000001 -> Lo=1 with WIDE_CMP_SIGNED_EN, Go=1 without; both after 1 CMP cycle.

Source files
------------

// File: rtl/wide_cmp_seq_pkg.sv
// ---------------------------------------------------------------------------
// wide_cmp_seq_pkg
// Shared definitions for the wide sequential comparator.
//   ST_IDLE / ST_CMP / ST_DONE : state encoding of the sequencer FSM
//   clog2_min1()               : index width helper, never returns less than 1
// ---------------------------------------------------------------------------
package wide_cmp_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMP  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // ceil(log2(v)), clamped to 1 so a K=1 build still has a 1-bit index.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/wide_cmp_seq_cmp_n.sv
// ---------------------------------------------------------------------------
// cmp_n
// Purely combinational N-bit unsigned magnitude comparator.
// Ports:
//   A, B  : N-bit unsigned operands
//   Go    : A > B
//   Eo    : A == B
//   Lo    : A < B
// Exactly one of Go/Eo/Lo is high for any input.
// ---------------------------------------------------------------------------
module cmp_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         Go,
  output logic         Eo,
  output logic         Lo
);

  assign Go = (A > B);
  assign Eo = (A == B);
  assign Lo = (A < B);

endmodule

// File: rtl/wide_cmp_seq.sv
// ---------------------------------------------------------------------------
// wide_cmp_seq
// Compares two W = N*K bit operands by walking one shared N-bit comparator
// over the slices, most significant slice first, stopping at the first
// unequal slice.
//
// Optional build macro: WIDE_CMP_SIGNED_EN
//   defined   : operands are two's complement; the sign bit of the top slice
//               is inverted on both comparator inputs (offset-binary trick),
//               lower slices stay unsigned.
//   undefined : pure unsigned compare.
//
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake (A, B sampled on transfer)
//   A, B                 : W-bit operands
//   out_valid / out_ready: result handshake
//   Go / Eo / Lo         : registered A>B / A==B / A<B, meaningful while
//                          out_valid=1, held until the next decision or reset
//   busy                 : FSM is not in IDLE
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE (and never during reset); out_valid is
// high exactly in DONE. No operand is accepted in the cycle the result leaves.
// ---------------------------------------------------------------------------
module wide_cmp_seq
  import wide_cmp_seq_pkg::*;
#(
  parameter  int N = 8,
  parameter  int K = 4,
  localparam int W = N * K
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         Go,
  output logic         Eo,
  output logic         Lo,
  output logic         busy
);

  localparam int IW = clog2_min1(K);
  localparam logic [IW-1:0] IDX_TOP = IW'(K - 1);

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_go;
  logic          r_eo;
  logic          r_lo;

  logic [N-1:0]  w_a_slice;
  logic [N-1:0]  w_b_slice;
  logic [N-1:0]  w_cmp_a;
  logic [N-1:0]  w_cmp_b;
  logic          w_go;
  logic          w_eo;
  logic          w_lo;
  logic          w_accept;
  logic          w_decide;

  // Slice select: shift the current slice down to bit 0 and keep N bits.
  assign w_a_slice = N'(r_a >> (N * int'(r_idx)));
  assign w_b_slice = N'(r_b >> (N * int'(r_idx)));

`ifdef WIDE_CMP_SIGNED_EN
  // Flipping the sign bit maps two's complement order onto unsigned order;
  // only the top slice carries a sign.
  always_comb begin
    w_cmp_a = w_a_slice;
    w_cmp_b = w_b_slice;
    if (r_idx == IDX_TOP) begin
      w_cmp_a[N-1] = ~w_a_slice[N-1];
      w_cmp_b[N-1] = ~w_b_slice[N-1];
    end
  end
`else
  assign w_cmp_a = w_a_slice;
  assign w_cmp_b = w_b_slice;
`endif

  cmp_n #(.N(N)) u_cmp (
    .A  (w_cmp_a),
    .B  (w_cmp_b),
    .Go (w_go),
    .Eo (w_eo),
    .Lo (w_lo)
  );

  assign w_accept = in_valid && in_ready;
  // A slice decides when it differs, or when the last slice is reached.
  assign w_decide = (r_state == ST_CMP) && (w_go || w_lo || (r_idx == '0));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_next_state = ST_CMP;
      ST_CMP:  if (w_decide)  w_next_state = ST_DONE;
      ST_DONE: if (out_ready) w_next_state = ST_IDLE;
      default:                w_next_state = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (r_state == ST_IDLE) && rst_n;
    out_valid = (r_state == ST_DONE);
    busy      = (r_state != ST_IDLE);
  end

  assign Go = r_go;
  assign Eo = r_eo;
  assign Lo = r_lo;

  // Slice index and result flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx <= IDX_TOP;
      r_go  <= 1'b0;
      r_eo  <= 1'b0;
      r_lo  <= 1'b0;
    end else if (w_accept) begin
      r_idx <= IDX_TOP;
    end else if (w_decide) begin
      // On a differing slice w_eo is 0; on the final equal slice Go/Lo are 0.
      r_go  <= w_go;
      r_eo  <= w_eo;
      r_lo  <= w_lo;
    end else if (r_state == ST_CMP) begin
      r_idx <= r_idx - 1'b1;
    end
  end

  // Operand latch; contents are irrelevant outside a compare, so no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= A;
      r_b <= B;
    end
  end

endmodule

// File: tb/tb_wide_cmp_seq.sv
module tb_wide_cmp_seq;
  localparam int N = 8;
  localparam int K = 4;
  localparam int W = N * K;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic         Go, Eo, Lo;
  logic         busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // expected {Go,Eo,Lo} results, pushed when an operation is issued
  logic [2:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  wide_cmp_seq #(.N(N), .K(K)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .Go(Go), .Eo(Eo), .Lo(Lo), .busy(busy)
  );

  // ---------------- reference model ----------------
  function automatic logic [2:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef WIDE_CMP_SIGNED_EN
    if ($signed(a) > $signed(b)) return 3'b100;
    if ($signed(a) < $signed(b)) return 3'b001;
`else
    if (a > b) return 3'b100;
    if (a < b) return 3'b001;
`endif
    return 3'b010;
  endfunction

  // CMP cycles = number of slices looked at, top down, up to the first difference
  function automatic int model_cmp_cycles(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] m;
    m = '0;
    m[N-1:0] = '1;
    for (int s = K - 1; s >= 0; s--)
      if (((a >> (s * N)) & m) != ((b >> (s * N)) & m)) return K - s;
    return K;
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle. Returns at the negedge after the
  // result handshake. lat counts cycles from the accept cycle to out_valid.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int rdy_dly,
                        output int lat, output logic [2:0] res, output int busy_n,
                        output logic stable_ok, output logic inrdy_ok);
    int k;
    A = a; B = b; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    @(negedge clk);
    in_valid = 1'b0;
    A = $urandom; B = $urandom;  // must not affect the compare in flight
    lat = 1; busy_n = 0; inrdy_ok = 1'b1; stable_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (busy) busy_n++;
      if (in_ready) inrdy_ok = 1'b0;
      @(negedge clk); lat++;
    end
    if (!out_valid) lat = -1;
    res = {Go, Eo, Lo};
    for (int i = 0; i < rdy_dly; i++) begin
      if (busy) busy_n++;
      if (in_ready) inrdy_ok = 1'b0;
      if (!out_valid || {Go, Eo, Lo} !== res) stable_ok = 1'b0;
      @(negedge clk);
    end
    out_ready = 1'b1;
    if (busy) busy_n++;
    if (in_ready) inrdy_ok = 1'b0;
    if (!out_valid || {Go, Eo, Lo} !== res) stable_ok = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, out_valid, Go, Eo, Lo, in_ready} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_state: busy/ov/G/E/L/in_ready=%b required 000000",
               {busy, out_valid, Go, Eo, Lo, in_ready});
    end
    rst_n = 1'b1; #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_in_ready: got %b required 1", in_ready);
    end
    @(negedge clk);
  endtask

  // Directed vectors with immediate out_ready (rdy_dly=0)
  task automatic test_vectors();
    logic [W-1:0] va[5];
    logic [W-1:0] vb[5];
    int lat, bn; logic [2:0] res, e; logic st, ir;
    va[0] = 32'h12345678; vb[0] = 32'h12345679;
    va[1] = 32'hDEADBEEF; vb[1] = 32'hDEADBEEF;
    va[2] = 32'h80000000; vb[2] = 32'h00000001;
    va[3] = 32'h00010000; vb[3] = 32'h0000FFFF;
    va[4] = 32'h00000000; vb[4] = 32'hFFFFFFFF;
    for (int v = 0; v < 5; v++) begin
      exp_q.push_back(model_res(va[v], vb[v]));
      run_op(va[v], vb[v], 0, lat, res, bn, st, ir);
      e = exp_q.pop_front();
      n_cmp++;
      if (res !== e) begin
        n_fail++; $display("FAIL vec%0d_result: GEL=%b required %b", v, res, e);
      end
      n_cmp++;
      if (lat != model_cmp_cycles(va[v], vb[v]) + 1) begin
        n_fail++; $display("FAIL vec%0d_latency: %0d required %0d", v, lat,
                           model_cmp_cycles(va[v], vb[v]) + 1);
      end
      n_cmp++;
      if (ir !== 1'b1) begin
        n_fail++; $display("FAIL vec%0d_in_ready_busy: in_ready seen high while busy", v);
      end
    end
  endtask

  // Top-slice decision; consumer answers one cycle after seeing out_valid
  task automatic test_go_early();
    int lat, bn; logic [2:0] res; logic st, ir;
    run_op(32'hFF000000, 32'h01000000, 1, lat, res, bn, st, ir);
    n_cmp++;
    if (res !== 3'b100) begin n_fail++; $display("FAIL early_result: GEL=%b required 100", res); end
    n_cmp++;
    if (lat != 2) begin n_fail++; $display("FAIL early_latency: %0d required 2", lat); end
    n_cmp++;
    if (bn != 3) begin n_fail++; $display("FAIL early_busy_cycles: %0d required 3", bn); end
  endtask

  task automatic test_backpressure();
    int lat, bn; logic [2:0] res; logic st, ir;
    run_op(32'h5, 32'h3, 5, lat, res, bn, st, ir);
    n_cmp++;
    if (res !== 3'b100) begin n_fail++; $display("FAIL bp_result: GEL=%b required 100", res); end
    n_cmp++;
    if (st !== 1'b1) begin n_fail++; $display("FAIL bp_stable: out_valid/flags changed under backpressure"); end
    n_cmp++;
    if (ir !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready: in_ready high during DONE/handshake cycle"); end
    n_cmp++;
    if (bn != model_cmp_cycles(32'h5, 32'h3) + 6) begin
      n_fail++; $display("FAIL bp_busy_cycles: %0d required %0d", bn, model_cmp_cycles(32'h5, 32'h3) + 6);
    end
    n_cmp++;
    if ({busy, out_valid, in_ready} !== 3'b001) begin
      n_fail++; $display("FAIL bp_after_handshake: busy/ov/in_ready=%b required 001", {busy, out_valid, in_ready});
    end
    n_cmp++;
    if ({Go, Eo, Lo} !== 3'b100) begin
      n_fail++; $display("FAIL bp_flags_held_idle: GEL=%b required 100", {Go, Eo, Lo});
    end
  endtask

  task automatic test_reset_mid();
    int lat, bn, k; logic [2:0] res; logic st, ir;
    A = 32'hCAFEF00D; B = 32'hCAFEF00D; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    @(negedge clk); in_valid = 1'b0;   // 1st CMP cycle
    @(negedge clk); rst_n = 1'b0;      // 2nd CMP cycle
    @(negedge clk);
    n_cmp++;
    if ({busy, out_valid, Go, Eo, Lo, in_ready} !== 6'b0) begin
      n_fail++; $display("FAIL midreset_state: busy/ov/G/E/L/in_ready=%b required 000000",
                         {busy, out_valid, Go, Eo, Lo, in_ready});
    end
    rst_n = 1'b1; #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready: %b required 1", in_ready); end
    @(negedge clk);
    run_op(32'h2, 32'h1, 0, lat, res, bn, st, ir);
    n_cmp++;
    if (res !== 3'b100) begin n_fail++; $display("FAIL midreset_first_op: GEL=%b required 100", res); end
  endtask

  // Results leave and operands enter with no idle gap: CMP cycles + 2 each
  task automatic test_back_to_back();
    logic [W-1:0] a, b; int lat, bn, c0, exp_cyc; logic [2:0] res, e; logic st, ir;
    c0 = cyc; exp_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = a ^ (32'h1 << $urandom_range(0, W - 1));
      exp_cyc += model_cmp_cycles(a, b) + 2;
      exp_q.push_back(model_res(a, b));
      run_op(a, b, 0, lat, res, bn, st, ir);
      e = exp_q.pop_front();
      n_cmp++;
      if (res !== e) begin n_fail++; $display("FAIL b2b%0d_result: GEL=%b required %b", i, res, e); end
    end
    n_cmp++;
    if (cyc - c0 != exp_cyc) begin
      n_fail++; $display("FAIL b2b_throughput: %0d cycles required %0d", cyc - c0, exp_cyc);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, m; int eq_sl, lat, bn, dly, cc; logic [2:0] res, e; logic st, ir;
    for (int i = 0; i < 30; i++) begin
      a = $urandom; b = $urandom;
      eq_sl = $urandom_range(0, K);  // force this many top slices equal
      m = '0;
      for (int s = 0; s < eq_sl; s++) m[W-1-s*N -: N] = '1;
      b = (a & m) | (b & ~m);
      dly = $urandom_range(0, 3);
      cc = model_cmp_cycles(a, b);
      exp_q.push_back(model_res(a, b));
      run_op(a, b, dly, lat, res, bn, st, ir);
      e = exp_q.pop_front();
      n_cmp++;
      if (res !== e || lat != cc + 1 || bn != cc + dly + 1 || st !== 1'b1 || ir !== 1'b1) begin
        n_fail++;
        $display("FAIL rand%0d: A=%h B=%h GEL=%b lat=%0d busy=%0d stable=%b inrdy=%b required GEL=%b lat=%0d busy=%0d stable=1 inrdy=1",
                 i, a, b, res, lat, bn, st, ir, e, cc + 1, cc + dly + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_go_early();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
